// File: rtl/wb_enclave_bridge.sv
// Wishbone slave between the management bus and the LWE enclave core:
// operand word packing, opcode handshake, result FIFO and status/pointer registers.
module wb_enclave_bridge #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] OPCODE_ADDR = 32'h3000_0000,
  parameter logic [31:0] DATA_ADDR   = 32'h2000_0000,
  parameter logic [31:0] OUTPUT_ADDR = 32'h1000_0000,
  parameter int unsigned RES_DEPTH   = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  opcode_valid_o,
  output logic [31:0]           opcode_o,
  input  logic                  opcode_ready_i,
  input  logic                  busy_i,
  input  logic                  res_valid_i,
  input  logic [31:0]           res_data_i,
  output logic                  res_ready_o
);

  localparam int unsigned WORDS = DATA_WIDTH / 32;
  localparam int unsigned LW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PW    = $clog2(RES_DEPTH);
  localparam int unsigned CW    = $clog2(RES_DEPTH + 1);
  localparam logic [31:0] STATUS_ADDR = OPCODE_ADDR + 32'd4;
  localparam logic [31:0] PTR_ADDR    = OPCODE_ADDR + 32'd8;

  logic [ADDR_WIDTH-1:0] ptr;
  logic [LW-1:0]         lane;
  logic [DATA_WIDTH-1:0] pack;
  logic [DATA_WIDTH-1:0] pack_merged;
  logic                  err_drop;
  logic                  err_underflow;
  logic [31:0]           fifo_mem [RES_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic [31:0]           status;
  logic [31:0]           rdata;

  logic acc, wr, rd, empty, full, push, pop;
  logic wr_data, wr_ptr_reg, wr_opc, wr_status, rd_out;
  logic set_drop, set_underflow;

  assign acc        = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr         = acc & wbs_we_i;
  assign rd         = acc & ~wbs_we_i;
  assign wr_data    = wr & (wbs_adr_i == DATA_ADDR);
  assign wr_ptr_reg = wr & (wbs_adr_i == PTR_ADDR);
  assign wr_opc     = wr & (wbs_adr_i == OPCODE_ADDR);
  assign wr_status  = wr & (wbs_adr_i == STATUS_ADDR);
  assign rd_out     = rd & (wbs_adr_i == OUTPUT_ADDR);

  assign empty         = (count == '0);
  assign full          = (count == CW'(RES_DEPTH));
  assign push          = res_valid_i & res_ready_o;
  assign pop           = rd_out & ~empty;
  assign set_underflow = rd_out & empty;
  assign set_drop      = wr_opc & opcode_valid_o;
  assign mem_addr_o    = ptr;

  assign status = {16'(ptr), 8'(count), 2'b00, err_underflow, err_drop,
                   full, empty, opcode_valid_o, busy_i};

  // Merge the selected byte lanes of the bus word into the current pack slice
  always_comb begin
    pack_merged = pack;
    for (int b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) pack_merged[32*int'(lane) + 8*b +: 8] = wbs_dat_i[8*b +: 8];
    end
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  always_comb begin
    rdata = '0;
    if (wbs_adr_i == OPCODE_ADDR)      rdata = opcode_o;
    else if (wbs_adr_i == STATUS_ADDR) rdata = status;
    else if (wbs_adr_i == PTR_ADDR)    rdata = 32'(ptr);
    else if (wbs_adr_i == OUTPUT_ADDR) rdata = empty ? 32'h0 : fifo_mem[rd_ptr];
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= res_data_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= '0;
      mem_we_o       <= 1'b0;
      mem_wdata_o    <= '0;
      opcode_valid_o <= 1'b0;
      opcode_o       <= '0;
      res_ready_o    <= 1'b0;
      ptr            <= '0;
      lane           <= '0;
      pack           <= '0;
      err_drop       <= 1'b0;
      err_underflow  <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rdata : 32'h0;
      mem_we_o  <= 1'b0;

      // Pointer advances after the cycle that presented it with the word
      if (mem_we_o) ptr <= ptr + ADDR_WIDTH'(1);

      if (wr_data) begin
        pack <= pack_merged;
        if (lane == LW'(WORDS - 1)) begin
          mem_we_o    <= 1'b1;
          mem_wdata_o <= pack_merged;
          lane        <= '0;
        end else begin
          lane <= lane + LW'(1);
        end
      end

      if (wr_ptr_reg) begin
        ptr  <= wbs_dat_i[ADDR_WIDTH-1:0];
        lane <= '0;
        pack <= '0;
      end

      if (opcode_valid_o && opcode_ready_i) opcode_valid_o <= 1'b0;
      if (wr_opc && !opcode_valid_o) begin
        opcode_o       <= wbs_dat_i;
        opcode_valid_o <= 1'b1;
      end

      err_drop      <= (err_drop & ~(wr_status & wbs_dat_i[4])) | set_drop;
      err_underflow <= (err_underflow & ~(wr_status & wbs_dat_i[5])) | set_underflow;

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count       <= count_next;
      res_ready_o <= (count_next != CW'(RES_DEPTH));
    end
  end

endmodule

// File: doc/wb_enclave_bridge.md
Name: wb_enclave_bridge

Overview:
- Parametrised Wishbone slave between the management bus and the LWE enclave core. It generalises the fixed-address opcode/output scheme to any DATA_WIDTH and adds:
  - packing of 32-bit bus writes into wide operand-memory words,
  - an opcode valid/ready handshake,
  - a result FIFO of depth RES_DEPTH,
  - a status/pointer register set.
- Sits directly under top, replacing ad-hoc bus decode.

Parameters:
- DATA_WIDTH, 128: operand memory word width; multiple of 32; WORDS = DATA_WIDTH/32.
- ADDR_WIDTH, 10: operand memory address width, at most 16.
- OPCODE_ADDR, 32'h30000000: opcode register. STATUS = OPCODE_ADDR+4, PTR = OPCODE_ADDR+8.
- DATA_ADDR, 32'h20000000: operand data write port.
- OUTPUT_ADDR, 32'h10000000: result FIFO read port.
- RES_DEPTH, 8: result FIFO entries; power of two, 2..128.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe / cycle / write-enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- mem_we_o  out  1  operand memory write strobe.
- mem_addr_o  out  ADDR_WIDTH  operand memory address.
- mem_wdata_o  out  DATA_WIDTH  packed operand word.
- opcode_valid_o  out  1  opcode pending.
- opcode_o  out  32  opcode value.
- opcode_ready_i  in  1  core accepts opcode.
- busy_i  in  1  core busy, reflected in status.
- res_valid_i  in  1  core result valid.
- res_data_i  in  32  result word.
- res_ready_o  out  1  FIFO not full.

Behaviour:
- Reset (wb_rst_i high at a rising edge):
  - All outputs are 0.
  - Lane counter, pointer, FIFO count and sticky errors are 0.
  - Partial pack register and pending opcode are discarded.
  - A bus cycle in flight is not acked; the master must retry.
- Bus accept: acc = stb & cyc & !ack.
  - wbs_ack_o is registered high in the cycle after acc and low the cycle after that. Single-cycle ack; minimum 2 cycles per transfer.
  - wbs_dat_o is registered with ack and is 0 whenever ack is low.
- Decode is an exact 32-bit match. Unmapped addresses are acked; reads return 0 and writes are ignored.
- DATA_ADDR write:
  - Byte lanes of wbs_dat_i selected by wbs_sel_i are written into pack slice [32*lane +: 32]; unselected bytes keep their old value.
  - lane increments on every accepted write.
  - When lane == WORDS-1:
    - next cycle mem_we_o pulses for exactly 1 cycle with mem_wdata_o = full packed word and mem_addr_o = ptr;
    - ptr then increments, wrapping 2^ADDR_WIDTH-1 -> 0;
    - lane resets to 0.
  - mem_addr_o always shows ptr.
  - DATA_ADDR reads return 0.
- PTR register:
  - Write: ptr <= wbs_dat_i[ADDR_WIDTH-1:0], lane <= 0, partial word discarded.
  - Read: returns zero-extended ptr.
- OPCODE_ADDR write:
  - If opcode_valid_o is low: opcode_o <= wbs_dat_i and opcode_valid_o <= 1 on the ack cycle.
  - If opcode_valid_o is high: the write is dropped and sticky err_drop is set.
  - opcode_valid_o clears the cycle after opcode_valid_o & opcode_ready_i.
  - A write coinciding with the accepting cycle counts as dropped.
  - Read returns opcode_o.
- STATUS read fields:
  - [0] busy_i
  - [1] opcode_valid_o
  - [2] fifo empty
  - [3] fifo full
  - [4] err_drop
  - [5] err_underflow
  - [15:8] count
  - [31:16] ptr
- STATUS write: a 1 in bit 4 clears err_drop; a 1 in bit 5 clears err_underflow. Set-on-same-cycle wins over clear.
- Result FIFO:
  - res_ready_o = (count != RES_DEPTH), driven from registers.
  - Push when res_valid_i & res_ready_o.
  - OUTPUT_ADDR read at acc:
    - if not empty: returns the head word and pops;
    - if empty: returns 0 and sets err_underflow.
  - Simultaneous push and pop: count is unchanged, and a push while full is not possible because res_ready_o is low.
  - Pointers wrap modulo RES_DEPTH.
  - OUTPUT_ADDR writes are ignored.

Test Plan:
- Reset: after reset, STATUS reads 32'h00000004 and all core-side outputs are 0; a reset asserted mid-transfer gives no ack.
- Packing (DATA_WIDTH=128): write PTR=5, then DATA_ADDR words 11111111, 22222222, 33333333, 44444444 with sel=F.
  - One mem_we_o pulse, addr 5, wdata 128'h44444444_33333333_22222222_11111111.
  - STATUS[31:16] reads 6.
- Partial/byte select:
  - Write sel=4'b0011 data AABBCCDD -> lane0 low half = CCDD, upper bytes retain their prior value.
  - PTR write after 2 words -> no mem_we_o; the next 4 data writes pack from lane 0.
  - PTR=1023 with 4 writes -> writes addr 1023, then ptr wraps to 0.
- Opcode handshake:
  - Write 0x7 with opcode_ready_i low -> opcode_valid_o=1 and opcode_o=7.
  - Second write 0x9 -> dropped, STATUS[4]=1.
  - Raise ready for 1 cycle -> valid clears.
  - Write STATUS with 0x10 -> bit 4 cleared.
- FIFO:
  - Push 8 results 0..7 -> res_ready_o low, STATUS[3]=1.
  - 8 OUTPUT_ADDR reads return 0..7 in order.
  - 9th read returns 0 and sets STATUS[5].
  - Push and pop in the same cycle at count=3 -> count stays 3.
- Unmapped: read 32'h40000000 -> acked with data 0; write has no side effects.
